// File: rtl/latch_bank_writer.sv
// latch_bank_writer: sequences setup/gate/hold write pulses and bank clears for a gated-latch bank.
module latch_bank_writer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 2,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1,
  parameter int CLR_CYC   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              clr_req_i,
  output logic [WIDTH-1:0]  lat_d_o,
  output logic [DEPTH-1:0]  lat_en_o,
  output logic              lat_clr_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              wr_err_o
);
  localparam int MAXC = (SETUP_CYC > PULSE_CYC ? SETUP_CYC : PULSE_CYC) > (HOLD_CYC > CLR_CYC ? HOLD_CYC : CLR_CYC)
                      ? (SETUP_CYC > PULSE_CYC ? SETUP_CYC : PULSE_CYC) : (HOLD_CYC > CLR_CYC ? HOLD_CYC : CLR_CYC);
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic [2:0] {IDLE, SETUP, GATE, HOLD, CLEAR, FIN} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]    lat_d_q, lat_d_d;
  logic [DEPTH-1:0]    lat_en_q, lat_en_d;
  logic                lat_clr_q, lat_clr_d, busy_q, busy_d, done_q, done_d;
  logic                err_q, err_d, ready_q, ready_d, oob;

  assign oob = 32'(addr_q) >= DEPTH;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CW'(1);
    addr_d  = addr_q;
    lat_d_d = lat_d_q;
    case (state_q)
      IDLE: begin
        cnt_d = cnt_q;
        if (clr_req_i) begin
          state_d = CLEAR;
          cnt_d   = CW'(CLR_CYC - 1);
        end else if (wr_valid_i && ready_q) begin
          state_d = SETUP;
          cnt_d   = CW'(SETUP_CYC - 1);
          addr_d  = wr_addr_i;
          lat_d_d = wr_data_i;
        end
      end
      SETUP: if (cnt_q == '0) begin
        state_d = GATE;
        cnt_d   = CW'(PULSE_CYC - 1);
      end
      GATE: if (cnt_q == '0) begin
        state_d = HOLD;
        cnt_d   = CW'(HOLD_CYC - 1);
      end
      HOLD:    if (cnt_q == '0) state_d = FIN;
      CLEAR:   if (cnt_q == '0) state_d = FIN;
      default: state_d = IDLE;
    endcase
    lat_en_d  = (state_d == GATE && 32'(addr_d) < DEPTH) ? DEPTH'(1) << addr_d : '0;
    lat_clr_d = state_d == CLEAR;
    busy_d    = state_d != IDLE && state_d != FIN;
    done_d    = state_d == FIN;
    err_d     = state_q == HOLD && state_d == FIN && oob;
    ready_d   = state_d == IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      lat_d_q   <= '0;
      lat_en_q  <= '0;
      lat_clr_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      lat_d_q   <= lat_d_d;
      lat_en_q  <= lat_en_d;
      lat_clr_q <= lat_clr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
    end
  end

  assign wr_ready_o = ready_q;
  assign lat_d_o    = lat_d_q;
  assign lat_en_o   = lat_en_q;
  assign lat_clr_o  = lat_clr_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign wr_err_o   = err_q;
endmodule

// File: tb/tb_latch_bank_writer.sv
// tb_latch_bank_writer: directed checks of write, clear, error, back-to-back and mid-write reset.
module tb_latch_bank_writer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic valid = 1'b0, clr = 1'b0;
  logic [1:0] addr = '0;
  logic [7:0] data = '0;
  logic ready, lclr, busy, done, err;
  logic [7:0] d;
  logic [3:0] en;
  logic e_valid = 1'b0;
  logic [2:0] e_addr = '0;
  logic [7:0] e_data = '0;
  logic e_ready, e_lclr, e_busy, e_done, e_err;
  logic [7:0] e_d;
  logic [3:0] e_en;
  logic [16:0] st, est;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  // status vector: {lat_d, lat_en, lat_clr, busy, done, wr_err, wr_ready}
  assign st  = {d, en, lclr, busy, done, err, ready};
  assign est = {e_d, e_en, e_lclr, e_busy, e_done, e_err, e_ready};

  latch_bank_writer u_dut (
    .clk(clk), .rst_n(rst_n), .wr_valid_i(valid), .wr_ready_o(ready), .wr_addr_i(addr),
    .wr_data_i(data), .clr_req_i(clr), .lat_d_o(d), .lat_en_o(en), .lat_clr_o(lclr),
    .busy_o(busy), .done_o(done), .wr_err_o(err)
  );

  latch_bank_writer #(.ADDR_W(3)) u_err (
    .clk(clk), .rst_n(rst_n), .wr_valid_i(e_valid), .wr_ready_o(e_ready), .wr_addr_i(e_addr),
    .wr_data_i(e_data), .clr_req_i(1'b0), .lat_d_o(e_d), .lat_en_o(e_en), .lat_clr_o(e_lclr),
    .busy_o(e_busy), .done_o(e_done), .wr_err_o(e_err)
  );

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (st !== 17'h0) begin errors++; $display("FAIL reset_hold got %h want %h", st, 17'h0); end
    checks++; if (est !== 17'h0) begin errors++; $display("FAIL reset_hold_e got %h want %h", est, 17'h0); end
    rst_n = 1'b1;
    #1;
    checks++; if (st !== 17'h0) begin errors++; $display("FAIL reset_release got %h want %h", st, 17'h0); end
    @(negedge clk);
    checks++; if (st !== 17'h1) begin errors++; $display("FAIL reset_ready got %h want %h", st, 17'h1); end
    checks++; if (est !== 17'h1) begin errors++; $display("FAIL reset_ready_e got %h want %h", est, 17'h1); end
  endtask

  task automatic test_write();
    logic [16:0] exp [1:6];
    exp = '{{8'hA5,4'b0000,5'b01000}, {8'hA5,4'b0100,5'b01000}, {8'hA5,4'b0100,5'b01000},
            {8'hA5,4'b0000,5'b01000}, {8'hA5,4'b0000,5'b00100}, {8'hA5,4'b0000,5'b00001}};
    valid = 1'b1; addr = 2'd2; data = 8'hA5;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      valid = 1'b0;
      checks++; if (st !== exp[i]) begin errors++; $display("FAIL write_c%0d got %h want %h", i, st, exp[i]); end
    end
  endtask

  task automatic test_clear_priority();
    logic [16:0] exp [1:10];
    exp = '{{8'hA5,4'b0000,5'b11000}, {8'hA5,4'b0000,5'b11000}, {8'hA5,4'b0000,5'b00100},
            {8'hA5,4'b0000,5'b00001}, {8'h3C,4'b0000,5'b01000}, {8'h3C,4'b0001,5'b01000},
            {8'h3C,4'b0001,5'b01000}, {8'h3C,4'b0000,5'b01000}, {8'h3C,4'b0000,5'b00100},
            {8'h3C,4'b0000,5'b00001}};
    clr = 1'b1; valid = 1'b1; addr = 2'd0; data = 8'h3C;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      clr = 1'b0;
      if (i == 6) valid = 1'b0;
      checks++; if (st !== exp[i]) begin errors++; $display("FAIL clear_c%0d got %h want %h", i, st, exp[i]); end
    end
  endtask

  task automatic test_addr_error();
    logic [16:0] exp [1:6];
    exp = '{{8'h77,4'b0000,5'b01000}, {8'h77,4'b0000,5'b01000}, {8'h77,4'b0000,5'b01000},
            {8'h77,4'b0000,5'b01000}, {8'h77,4'b0000,5'b00110}, {8'h77,4'b0000,5'b00001}};
    e_valid = 1'b1; e_addr = 3'd5; e_data = 8'h77;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      e_valid = 1'b0;
      checks++; if (est !== exp[i]) begin errors++; $display("FAIL err_c%0d got %h want %h", i, est, exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp [1:12];
    logic [7:0] pd;
    logic [3:0] pen;
    exp = '{{8'h11,4'b0000,5'b01000}, {8'h11,4'b0010,5'b01000}, {8'h11,4'b0010,5'b01000},
            {8'h11,4'b0000,5'b01000}, {8'h11,4'b0000,5'b00100}, {8'h11,4'b0000,5'b00001},
            {8'h22,4'b0000,5'b01000}, {8'h22,4'b1000,5'b01000}, {8'h22,4'b1000,5'b01000},
            {8'h22,4'b0000,5'b01000}, {8'h22,4'b0000,5'b00100}, {8'h22,4'b0000,5'b00001}};
    valid = 1'b1; addr = 2'd1; data = 8'h11;
    pd = d; pen = en;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) begin addr = 2'd3; data = 8'h22; end
      if (i == 11) valid = 1'b0;
      checks++; if (st !== exp[i]) begin errors++; $display("FAIL b2b_c%0d got %h want %h", i, st, exp[i]); end
      checks++; if ((en != 4'b0 || pen != 4'b0) && d !== pd) begin errors++; $display("FAIL b2b_dstable_c%0d got %h want %h", i, d, pd); end
      pd = d; pen = en;
    end
  endtask

  task automatic test_reset_mid_gate();
    valid = 1'b1; addr = 2'd1; data = 8'h5A;
    @(negedge clk);
    valid = 1'b0;
    checks++; if (st !== {8'h5A,4'b0000,5'b01000}) begin errors++; $display("FAIL rst_setup got %h want %h", st, {8'h5A,4'b0000,5'b01000}); end
    @(negedge clk);
    checks++; if (st !== {8'h5A,4'b0010,5'b01000}) begin errors++; $display("FAIL rst_gate got %h want %h", st, {8'h5A,4'b0010,5'b01000}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (st !== 17'h0) begin errors++; $display("FAIL rst_async got %h want %h", st, 17'h0); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (st !== 17'h0) begin errors++; $display("FAIL rst_release got %h want %h", st, 17'h0); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++; if (st !== 17'h1) begin errors++; $display("FAIL rst_after_c%0d got %h want %h", i, st, 17'h1); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_clear_priority();
    test_addr_error();
    test_back_to_back();
    test_reset_mid_gate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
